// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver. It synchronises and deglitches the raw lines,
// deserialises 11-bit frames and emits either a one-cycle scancode strobe or an error strobe.
module ps2_frame_receiver #(
  parameter logic [3:0]  FILTER_LEN     = 4'd8,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd20_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_strb,
  output logic       rx_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic        clk_meta_q, clk_sync_q;
  logic        data_meta_q, data_sync_q;
  logic        fclk_q, fclk_d;
  logic        fclk_dly_q;
  logic [3:0]  filt_cnt_q, filt_cnt_d;
  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        parity_q, parity_d;
  logic [23:0] to_cnt_q, to_cnt_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_strb_q, rx_strb_d;
  logic        rx_err_q, rx_err_d;
  logic        busy_q, busy_d;
  logic        fall;
  logic        timeout_hit;

  // Both lines idle high, so the synchronisers come out of reset at 1 to avoid a false start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  always_comb begin
    fclk_d     = fclk_q;
    filt_cnt_d = 4'd0;
    if (clk_sync_q != fclk_q) begin
      if (filt_cnt_q == FILTER_LEN) begin
        fclk_d     = clk_sync_q;
        filt_cnt_d = 4'd0;
      end else begin
        filt_cnt_d = filt_cnt_q + 4'd1;
      end
    end
  end

  assign fall        = fclk_dly_q & ~fclk_q;
  assign timeout_hit = (state_q != IDLE) && (to_cnt_q == (TIMEOUT_CYCLES - 24'd1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (fall || (state_q == IDLE)) begin
      to_cnt_d = 24'd0;
    end else if (to_cnt_q != 24'hFF_FFFF) begin
      to_cnt_d = to_cnt_q + 24'd1;
    end
  end

  // A real edge always beats a coincident timeout, so the timeout branch only runs without an edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    rx_data_d = rx_data_q;
    rx_strb_d = 1'b0;
    rx_err_d  = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_sync_q) begin
            shift_d   = 8'h00;
            bit_cnt_d = 3'd0;
            state_d   = DATA;
          end
        end
        DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = data_sync_q;
          state_d  = STOP;
        end
        STOP: begin
          if (data_sync_q && (^{shift_q, parity_q})) begin
            rx_data_d = shift_q;
            rx_strb_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      rx_err_d  = 1'b1;
      state_d   = IDLE;
      shift_d   = 8'h00;
      bit_cnt_d = 3'd0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fclk_q     <= 1'b1;
      fclk_dly_q <= 1'b1;
      filt_cnt_q <= 4'd0;
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      parity_q   <= 1'b0;
      to_cnt_q   <= 24'd0;
      rx_data_q  <= 8'h00;
      rx_strb_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      fclk_q     <= fclk_d;
      fclk_dly_q <= fclk_q;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      parity_q   <= parity_d;
      to_cnt_q   <= to_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_strb_q  <= rx_strb_d;
      rx_err_q   <= rx_err_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_strb = rx_strb_q;
  assign rx_err  = rx_err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: directed PS/2 frames push expected events,
// a monitor pops them whenever rx_strb or rx_err fires.
module tb_ps2_frame_receiver;

  localparam logic [3:0]  FL   = 4'd8;
  localparam logic [23:0] TC   = 24'd500;
  localparam int          HALF = 30;

  typedef struct {
    bit         isErr;
    logic [7:0] data;
    int         cycLo;
    int         cycHi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] rxData;
  logic       rxStrb;
  logic       rxErr;
  logic       busy;

  exp_t       expQ[$];
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] lastGood = 8'h00;

  ps2_frame_receiver #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk),
    .rst_n(rstN),
    .ps2_clk(ps2Clk),
    .ps2_data(ps2Data),
    .rx_data(rxData),
    .rx_strb(rxStrb),
    .rx_err(rxErr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  function automatic logic [10:0] mkFrame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  // The stop bit's outcome is fully known when its clock goes low, so the expectation is pushed then.
  task automatic pushStop(input logic [10:0] f, input int lowCyc);
    exp_t       e;
    logic [7:0] d;
    d = f[8:1];
    e.cycLo = lowCyc + int'(FL) + 4;
    e.cycHi = e.cycLo;
    if (f[10] && (^{d, f[9]})) begin
      e.isErr  = 1'b0;
      e.data   = d;
      lastGood = d;
    end else begin
      e.isErr = 1'b1;
      e.data  = lastGood;
    end
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [10:0] f, input int first, input int last, output int lastLow);
    lastLow = 0;
    for (int i = first; i <= last; i++) begin
      ps2Data = f[i];
      repeat (HALF) @(negedge clk);
      ps2Clk  = 1'b0;
      lastLow = cyc;
      if (i == 10) pushStop(f, lastLow);
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s);
    int c;
    applyStimulus(mkFrame(d, p, s), 0, 10, c);
  endtask

  task automatic glitch(input int lowLen);
    repeat (10) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (lowLen) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d events still pending, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: every strobe or error must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rstN && (rxStrb || rxErr)) begin
      checkOutput("strb_err_exclusive", {31'b0, rxStrb & rxErr}, 32'd0);
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_event: strb=%0b err=%0b data=%02h at cycle %0d, required no event",
                 rxStrb, rxErr, rxData, cyc);
      end else begin
        e = expQ.pop_front();
        checkOutput("event_is_err", {31'b0, rxErr}, {31'b0, e.isErr});
        checkOutput("rx_data", {24'b0, rxData}, {24'b0, e.data});
        compared++;
        if ((cyc < e.cycLo) || (cyc > e.cycHi)) begin
          mismatched++;
          $display("[TB] FAIL event_timing: got cycle %0d, required %0d..%0d", cyc, e.cycLo, e.cycHi);
        end
      end
    end
  end

  initial begin
    int   c;
    exp_t e;
    rstN    = 1'b0;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_rx_data", {24'b0, rxData}, 32'h00);
    checkOutput("reset_rx_strb", {31'b0, rxStrb}, 32'd0);
    checkOutput("reset_rx_err", {31'b0, rxErr}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    rstN = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] valid frame 0x1C");
    applyStimulus(mkFrame(8'h1C, 1'b0, 1'b1), 0, 0, c);
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
    applyStimulus(mkFrame(8'h1C, 1'b0, 1'b1), 1, 10, c);
    waitDrain(200);
    checkOutput("busy_after_frame", {31'b0, busy}, 32'd0);

    $display("[TB] back-to-back 0xF0 then 0x1C");
    sendFrame(8'hF0, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    checkOutput("busy_in_gap", {31'b0, busy}, 32'd0);
    repeat (50) @(negedge clk);
    sendFrame(8'h1C, 1'b0, 1'b1);
    waitDrain(200);

    $display("[TB] bad parity and bad stop");
    sendFrame(8'h1C, 1'b1, 1'b1);
    sendFrame(8'h1C, 1'b0, 1'b0);
    waitDrain(200);
    checkOutput("rx_data_held_after_errors", {24'b0, rxData}, 32'h1C);

    $display("[TB] further patterns");
    sendFrame(8'hA5, 1'b1, 1'b1);
    sendFrame(8'hFF, 1'b1, 1'b1);
    sendFrame(8'h00, 1'b1, 1'b1);
    sendFrame(8'h00, 1'b0, 1'b1);
    waitDrain(200);

    $display("[TB] timeout after 5 data bits");
    applyStimulus(mkFrame(8'h5A, 1'b1, 1'b1), 0, 5, c);
    checkOutput("busy_before_timeout", {31'b0, busy}, 32'd1);
    e.isErr = 1'b1;
    e.data  = lastGood;
    e.cycLo = c + int'(FL) + int'(TC) + 2;
    e.cycHi = c + int'(FL) + int'(TC) + 6;
    expQ.push_back(e);
    waitDrain(int'(TC) + 200);
    checkOutput("busy_after_timeout", {31'b0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    sendFrame(8'h1C, 1'b0, 1'b1);
    waitDrain(200);

    $display("[TB] glitches on ps2_clk");
    glitch(3);
    checkOutput("busy_after_idle_glitch", {31'b0, busy}, 32'd0);
    applyStimulus(mkFrame(8'h3C, 1'b1, 1'b1), 0, 3, c);
    glitch(3);
    checkOutput("busy_after_frame_glitch", {31'b0, busy}, 32'd1);
    applyStimulus(mkFrame(8'h3C, 1'b1, 1'b1), 4, 10, c);
    waitDrain(200);

    $display("[TB] reset mid-frame");
    applyStimulus(mkFrame(8'h77, 1'b1, 1'b1), 0, 4, c);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midreset_rx_data", {24'b0, rxData}, 32'h00);
    checkOutput("midreset_rx_strb", {31'b0, rxStrb}, 32'd0);
    checkOutput("midreset_rx_err", {31'b0, rxErr}, 32'd0);
    checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
    lastGood = 8'h00;
    repeat (5) @(negedge clk);
    rstN = 1'b1;
    repeat (100) @(negedge clk);
    sendFrame(8'h1C, 1'b0, 1'b1);
    waitDrain(200);

    repeat (50) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_frame_receiver.md
# ps2_frame_receiver

Front-end stage of the PS/2-to-Morse path. It samples the raw keyboard `ps2_clk`/`ps2_data` lines from the bidirectional pins, synchronises and deglitches them, and deserialises 11-bit PS/2 device-to-host frames. It delivers each validated scancode byte with a one-cycle strobe to the downstream data-control stage. Frames with bad parity, a bad stop bit, or a stalled clock are dropped and flagged.

## Interface

- `FILTER_LEN`, default 4'd8: consecutive identical synchronised `ps2_clk` samples required before the filtered clock changes. Range 1..15.
- `TIMEOUT_CYCLES`, default 24'd20_000: idle-clock limit inside a frame; at 10 MHz this is 2 ms.
- `clk`  in  1: system clock, single clock domain.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ps2_clk`  in  1: raw PS/2 clock, asynchronous, idle high.
- `ps2_data`  in  1: raw PS/2 data, asynchronous, idle high.
- `rx_data`  out  8: last valid scancode. Holds its value until the next valid frame.
- `rx_strb`  out  1: one-cycle pulse; `rx_data` is new in the same cycle.
- `rx_err`  out  1: one-cycle pulse on a parity, stop or timeout error.
- `busy`  out  1: high while a frame is in progress (state ≠ IDLE).

## Operation

- **Synchronisers:** 2-FF synchronisers on both lines. Their reset value is 1.
- **Clock filter:**
  - A counter of width 4 compares the synchronised `ps2_clk` with the filtered clock `fclk` (reset 1).
  - While the two differ, the counter increments. When the count reaches `FILTER_LEN`, `fclk` takes the synchronised value and the counter clears.
  - Any cycle where they match clears the counter.
- **Edge detect:** a falling edge is `fclk_q & ~fclk`, where `fclk_q` is `fclk` registered. Synchronised `ps2_data` is sampled in that cycle.
- **FSM:** states IDLE, DATA, PARITY, STOP. Transitions occur only on a filtered falling edge or on timeout.
  - IDLE:
    - Sampled data 0 (start bit): clear the shift register and the 3-bit bit counter, then go to DATA.
    - Sampled data 1: stay in IDLE, no error.
  - DATA:
    - Shift right, inserting at bit 7, so the byte is assembled LSB first.
    - After the 8th bit (counter wraps 7→0), go to PARITY.
  - PARITY: store the parity bit, then go to STOP.
  - STOP:
    - Valid frame: stop bit = 1 and XOR of the 8 data bits and the parity bit = 1 (odd parity). Load `rx_data` from the shift register, pulse `rx_strb`, go to IDLE.
    - Otherwise: pulse `rx_err`, leave `rx_data` unchanged, go to IDLE.
- **Timeout:**
  - A 24-bit counter clears on every filtered falling edge and while in IDLE. It increments otherwise.
  - When it reaches `TIMEOUT_CYCLES-1` in any non-IDLE state:
    - pulse `rx_err`,
    - go to IDLE,
    - discard the partial byte.
  - The counter saturates; it never wraps.
- **Simultaneous events:** if a falling edge and the timeout terminal count occur in the same cycle, the edge wins and the counter clears.
- **Strobe exclusivity:** `rx_strb` and `rx_err` are never high in the same cycle.
- **Reset values** (any time, including mid-frame):
  - `rx_data` = 8'h00, `rx_strb` = 0, `rx_err` = 0, `busy` = 0
  - state IDLE
  - `fclk` = 1, all counters 0
- **After reset release mid-frame:** the remainder of the interrupted frame is treated as fresh traffic. A data-1 bit sampled in IDLE is ignored. A data-0 bit starts a frame that ends in an error or a timeout.

## Timing

- All outputs are registered.
- Raw `ps2_clk` low first sampled at edge N (with data stable): `fclk` falls at N+2+`FILTER_LEN`, and the edge-detect cycle follows.
- `rx_strb`/`rx_err` for a stop bit are high during cycle N+`FILTER_LEN`+3 relative to the stop-bit clock fall.
- Strobes are exactly 1 cycle wide. There is no handshake; the consumer must capture on `rx_strb`.
- Minimum legal PS/2 clock low/high time is (`FILTER_LEN`+2) cycles. Shorter pulses are glitches and are ignored.
- `busy` rises the cycle after the start-bit edge. It falls in the same cycle that `rx_strb`/`rx_err` is high.

## Test plan

- **Valid frame:** send 0x1C (start 0, bits LSB first 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 60 µs clock period → exactly one `rx_strb`, `rx_data` = 0x1C, `rx_err` never high.
- **Back-to-back frames:** 0xF0 (parity 1) then 0x1C with a 100 µs gap → two strobes with `rx_data` 0xF0 then 0x1C; `busy` low between frames.
- **Bad parity:** 0x1C with parity 1 → `rx_err` pulse, no `rx_strb`, `rx_data` keeps the previous value.
- **Bad stop:** stop bit 0 → same result as the bad-parity case.
- **Timeout:** stop `ps2_clk` after 5 data bits → `rx_err` pulses `TIMEOUT_CYCLES` cycles after the last filtered fall, `busy` drops, and a following valid 0x1C frame is received correctly.
- **Glitch and reset:**
  - A 3-cycle low glitch on `ps2_clk` (`FILTER_LEN`=8) → no bit sampled, state unchanged.
  - Assert `rst_n` low mid-frame → all outputs return to their reset values immediately. Reception resumes correctly with the next valid frame.
